// File: rtl/cmp_stable_tracker.sv
`default_nettype none
// ============================================================================
// cmp_stable_tracker : registered WIDTH-bit magnitude compare with debounce lock
// Rev 1.0 : initial release
// ============================================================================
module cmp_stable_tracker #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED     = 1'b0,
  parameter int STABLE_CNT = 4,
  localparam int CNT_W     = $clog2(STABLE_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             ALB,
  output logic             AEB,
  output logic             ASB,
  output logic [CNT_W-1:0] streak,
  output logic             stable,
  output logic             stable_ALB,
  output logic             stable_AEB,
  output logic             stable_ASB,
  output logic             change
);

  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic a_gt_b;
  logic a_lt_b;

  generate
    if (SIGNED) begin : g_signed
      assign a_gt_b = $signed(A) > $signed(B);
      assign a_lt_b = $signed(A) < $signed(B);
    end else begin : g_unsigned
      assign a_gt_b = A > B;
      assign a_lt_b = A < B;
    end
  endgenerate

  // Results are kept one-hot as {gt, eq, lt}; all-zero means "none yet".
  logic [2:0] res_new;
  assign res_new = {a_gt_b, ~(a_gt_b | a_lt_b), a_lt_b};

  state_t           state_q, state_d;
  logic [2:0]       res_q, res_d;
  logic [2:0]       stable_res_q, stable_res_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             out_valid_q, out_valid_d;
  logic             change_q, change_d;
  logic             lock;

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    stable_res_d = stable_res_q;
    streak_d     = streak_q;
    out_valid_d  = in_valid;
    change_d     = 1'b0;
    lock         = 1'b0;

    if (in_valid) begin
      res_d = res_new;

      if (state_q == ST_EMPTY || res_new != res_q) begin
        streak_d = C_ONE;
      end else if (streak_q >= C_SAT) begin
        streak_d = C_SAT;
      end else begin
        streak_d = streak_q + C_ONE;
      end

      case (state_q)
        ST_EMPTY: begin
          state_d = ST_TRACK;
          lock    = (streak_d >= C_SAT);
        end
        ST_TRACK: begin
          lock = (streak_d >= C_SAT);
        end
        ST_LOCKED: begin
          if (res_new != res_q) state_d = ST_TRACK;
        end
        default: state_d = ST_EMPTY;
      endcase

      // A cleared locked history is all-zero, so it never matches a one-hot result.
      if (lock) begin
        state_d      = ST_LOCKED;
        stable_res_d = res_new;
        change_d     = (res_new != stable_res_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      res_q        <= 3'b000;
      stable_res_q <= 3'b000;
      streak_q     <= '0;
      out_valid_q  <= 1'b0;
      change_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      stable_res_q <= stable_res_d;
      streak_q     <= streak_d;
      out_valid_q  <= out_valid_d;
      change_q     <= change_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ALB        = res_q[2];
  assign AEB        = res_q[1];
  assign ASB        = res_q[0];
  assign streak     = streak_q;
  assign stable     = (state_q == ST_LOCKED);
  assign stable_ALB = stable_res_q[2];
  assign stable_AEB = stable_res_q[1];
  assign stable_ASB = stable_res_q[0];
  assign change     = change_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_stable_tracker.sv
`default_nettype none
// ============================================================================
// tb_cmp_stable_tracker : unsigned and signed instances against a behavioural model
// Rev 1.0 : initial release
// ============================================================================
module tb_cmp_stable_tracker;

  localparam int W     = 8;
  localparam int SC    = 4;
  localparam int CNT_W = $clog2(SC + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;

  logic [1:0]            ov, alb, aeb, asb, stb, s_alb, s_aeb, s_asb, chg;
  logic [1:0][CNT_W-1:0] strk;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_stable_tracker #(.WIDTH(W), .SIGNED(1'b0), .STABLE_CNT(SC)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_in), .B(b_in),
    .out_valid(ov[0]), .ALB(alb[0]), .AEB(aeb[0]), .ASB(asb[0]),
    .streak(strk[0]), .stable(stb[0]),
    .stable_ALB(s_alb[0]), .stable_AEB(s_aeb[0]), .stable_ASB(s_asb[0]),
    .change(chg[0])
  );

  cmp_stable_tracker #(.WIDTH(W), .SIGNED(1'b1), .STABLE_CNT(SC)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_in), .B(b_in),
    .out_valid(ov[1]), .ALB(alb[1]), .AEB(aeb[1]), .ASB(asb[1]),
    .streak(strk[1]), .stable(stb[1]),
    .stable_ALB(s_alb[1]), .stable_AEB(s_aeb[1]), .stable_ASB(s_asb[1]),
    .change(chg[1])
  );

  // Reference state per instance; results coded 0:A>B 1:A==B 2:A<B, -1 none.
  int m_raw    [2];
  int m_lres   [2];
  int m_streak [2];
  bit m_locked [2];
  bit m_ov     [2];
  bit m_chg    [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int cmp_code(input int a, input int b, input bit sgn);
    int sa, sb;
    sa = (sgn && a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (sgn && b >= (1 << (W - 1))) ? b - (1 << W) : b;
    if (sa > sb) return 0;
    if (sa == sb) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_raw[d] = -1; m_lres[d] = -1; m_streak[d] = 0;
      m_locked[d] = 1'b0; m_ov[d] = 1'b0; m_chg[d] = 1'b0;
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int a, input int b);
    int res;
    if (r) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_ov[d]  = v;
      m_chg[d] = 1'b0;
      if (v) begin
        res = cmp_code(a, b, d == 1);
        if (m_raw[d] < 0 || res != m_raw[d]) m_streak[d] = 1;
        else m_streak[d] = (m_streak[d] + 1 > SC) ? SC : m_streak[d] + 1;
        if (m_locked[d]) begin
          if (res != m_raw[d]) m_locked[d] = 1'b0;
        end else if (m_streak[d] >= SC) begin
          m_locked[d] = 1'b1;
          m_chg[d]    = (m_lres[d] != res);
          m_lres[d]   = res;
        end
        m_raw[d] = res;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d out_valid", d), int'(ov[d]), int'(m_ov[d]));
      check_val($sformatf("d%0d ALB", d), int'(alb[d]), int'(m_raw[d] == 0));
      check_val($sformatf("d%0d AEB", d), int'(aeb[d]), int'(m_raw[d] == 1));
      check_val($sformatf("d%0d ASB", d), int'(asb[d]), int'(m_raw[d] == 2));
      check_val($sformatf("d%0d streak", d), int'(strk[d]), m_streak[d]);
      check_val($sformatf("d%0d stable", d), int'(stb[d]), int'(m_locked[d]));
      check_val($sformatf("d%0d stable_ALB", d), int'(s_alb[d]), int'(m_lres[d] == 0));
      check_val($sformatf("d%0d stable_AEB", d), int'(s_aeb[d]), int'(m_lres[d] == 1));
      check_val($sformatf("d%0d stable_ASB", d), int'(s_asb[d]), int'(m_lres[d] == 2));
      check_val($sformatf("d%0d change", d), int'(chg[d]), int'(m_chg[d]));
    end
  endtask

  task automatic step(input bit r, input bit v, input int a, input int b);
    rst      = r;
    in_valid = v;
    a_in     = W'(a);
    b_in     = W'(b);
    @(posedge clk);
    model_step(r, v, a, b);
    #1;
    check_all();
  endtask

  initial begin
    int ra, rb;
    model_reset();

    // Reset dominates a valid sample, then first sample A>B.
    step(1, 1, 5, 3);
    step(1, 1, 5, 3);
    step(0, 1, 5, 3);
    check_val("post-reset ALB", int'(alb[0]), 1);
    check_val("post-reset streak", int'(strk[0]), 1);

    // Signedness: 200 vs 100 differs between instances.
    step(0, 1, 200, 100);
    check_val("unsigned 200>100", int'(alb[0]), 1);
    check_val("signed -56<100", int'(asb[1]), 1);

    // Lock on equal operands, streak saturates.
    for (int i = 0; i < 5; i++) step(0, 1, 8'h3C, 8'h3C);
    check_val("lock stable_AEB", int'(s_aeb[0]), 1);

    // Glitch then relock to same result: no change pulse.
    step(0, 1, 9, 3);
    for (int i = 0; i < 4; i++) step(0, 1, 7, 7);

    // Flip to A<B with idle gaps between samples.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2, 90);
      step(0, 0, 90, 2);
      step(0, 0, 0, 0);
    end

    // Reset mid-streak, then relock with change.
    for (int i = 0; i < 3; i++) step(0, 1, 50, 10);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 50, 10);

    // Randomized phase: sticky operands to build streaks, sparse resets.
    ra = 0; rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ra = $urandom_range(0, 255);
        case ($urandom_range(0, 2))
          0: rb = ra;
          1: rb = $urandom_range(0, 255);
          default: rb = (ra + 128) % 256;
        endcase
      end
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
